// File: rtl/mac_tile_dual.sv
// rtl/mac_tile_dual.sv - dual-mode (weight-/output-stationary) systolic PE tile
// Activations/instructions flow west->east, psums/weights/drain data flow north->south.
module mac_tile_dual #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int SAT     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  input  logic [psum_bw-1:0] in_n,
  input  logic [2:0]         inst_w,
  output logic [bw-1:0]      out_e,
  output logic [psum_bw-1:0] out_s,
  output logic [2:0]         inst_e,
  output logic               ovf
);
  localparam int SW = psum_bw + 1;
  localparam logic [psum_bw-1:0] PMAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] PMIN = {1'b1, {(psum_bw-1){1'b0}}};

  logic [bw-1:0]      a_q, a_d;
  logic [psum_bw-1:0] s_q, s_d;
  logic [2:0]         inst_e_q, inst_e_d;
  logic               ovf_q, ovf_d;
  logic [bw-1:0]      w_active_q, w_active_d;
  logic [bw-1:0]      w_shadow_q, w_shadow_d;
  logic               shadow_valid_q, shadow_valid_d;
  logic [psum_bw-1:0] acc_q, acc_d;
  logic               exec_prev_q, flush_prev_q, mode_q;

  logic exec, exec_rise, flush_rise, mode_chg, capture, promote;
  logic [bw-1:0]      w_eff, op_w;
  logic [psum_bw-1:0] op_add, mac_res;
  logic signed [SW-1:0] a_ext, w_ext, add_ext, prod, sum;
  logic sum_ovf;

  assign exec       = inst_w[1];
  assign exec_rise  = exec & ~exec_prev_q;
  assign flush_rise = inst_w[2] & ~flush_prev_q;
  assign mode_chg   = mode != mode_q;
  assign capture    = ~mode_q & inst_w[0] & ~exec & ~shadow_valid_q;
  assign promote    = ~mode_q & exec_rise & shadow_valid_q;
  // A freshly promoted shadow weight is used in the very cycle it is promoted.
  assign w_eff      = promote ? w_shadow_q : w_active_q;

  assign op_w    = mode_q ? in_n[bw-1:0] : w_eff;
  assign op_add  = mode_q ? acc_q : in_n;
  assign a_ext   = SW'($signed({1'b0, in_w}));
  assign w_ext   = SW'($signed(op_w));
  assign add_ext = SW'($signed(op_add));
  assign prod    = a_ext * w_ext;
  assign sum     = prod + add_ext;
  assign sum_ovf = sum[SW-1] ^ sum[SW-2];

  always_comb begin
    mac_res = sum[psum_bw-1:0];
    if (sum_ovf && SAT != 0) mac_res = sum[SW-1] ? PMIN : PMAX;
  end

  always_comb begin
    a_d            = (inst_w[0] | inst_w[1]) ? in_w : a_q;
    s_d            = s_q;
    inst_e_d       = {inst_w[2], inst_w[1], inst_w[0] & ~capture};
    ovf_d          = ovf_q;
    w_active_d     = w_active_q;
    w_shadow_d     = w_shadow_q;
    shadow_valid_d = shadow_valid_q;
    acc_d          = acc_q;

    if (exec && sum_ovf) ovf_d = 1'b1;
    else if (flush_rise) ovf_d = 1'b0;

    if (!mode_q) begin
      if (capture) begin
        w_shadow_d     = in_w;
        shadow_valid_d = 1'b1;
      end
      if (promote) begin
        w_active_d     = w_shadow_q;
        shadow_valid_d = 1'b0;
      end
      if (exec) s_d = mac_res;
    end else begin
      // Execute beats a simultaneous flush edge; the accumulator is then not drained.
      if (exec) begin
        acc_d = mac_res;
        s_d   = psum_bw'($signed(in_n[bw-1:0]));
      end else if (flush_rise) begin
        s_d   = acc_q;
        acc_d = '0;
      end else if (inst_w[2]) begin
        s_d   = in_n;
      end
    end

    if (mode_chg) begin
      acc_d          = '0;
      shadow_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q            <= '0;
      s_q            <= '0;
      inst_e_q       <= '0;
      ovf_q          <= 1'b0;
      w_active_q     <= '0;
      w_shadow_q     <= '0;
      shadow_valid_q <= 1'b0;
      acc_q          <= '0;
      exec_prev_q    <= 1'b0;
      flush_prev_q   <= 1'b0;
      mode_q         <= 1'b0;
    end else begin
      a_q            <= a_d;
      s_q            <= s_d;
      inst_e_q       <= inst_e_d;
      ovf_q          <= ovf_d;
      w_active_q     <= w_active_d;
      w_shadow_q     <= w_shadow_d;
      shadow_valid_q <= shadow_valid_d;
      acc_q          <= acc_d;
      exec_prev_q    <= inst_w[1];
      flush_prev_q   <= inst_w[2];
      mode_q         <= mode;
    end
  end

  assign out_e  = a_q;
  assign out_s  = s_q;
  assign inst_e = inst_e_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_mac_tile_dual.sv
// tb/tb_mac_tile_dual.sv - directed vector bench for mac_tile_dual
// Main tile at 4/16 bits plus two 8-bit psum tiles (saturating and wrapping).
module tb_mac_tile_dual;
  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [3:0]  in_w;
  logic [15:0] in_n;
  logic [7:0]  in_n8;
  logic [2:0]  inst_w;
  logic [3:0]  out_e, out_e_s8, out_e_w8;
  logic [15:0] out_s;
  logic [7:0]  out_s_s8, out_s_w8;
  logic [2:0]  inst_e, inst_e_s8, inst_e_w8;
  logic        ovf, ovf_s8, ovf_w8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign in_n8 = in_n[7:0];

  mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(1)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .in_n(in_n), .inst_w(inst_w),
    .out_e(out_e), .out_s(out_s), .inst_e(inst_e), .ovf(ovf));

  mac_tile_dual #(.bw(4), .psum_bw(8), .SAT(1)) dut_s8 (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .in_n(in_n8), .inst_w(inst_w),
    .out_e(out_e_s8), .out_s(out_s_s8), .inst_e(inst_e_s8), .ovf(ovf_s8));

  mac_tile_dual #(.bw(4), .psum_bw(8), .SAT(0)) dut_w8 (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .in_n(in_n8), .inst_w(inst_w),
    .out_e(out_e_w8), .out_s(out_s_w8), .inst_e(inst_e_w8), .ovf(ovf_w8));

  typedef struct {
    logic        md;
    logic [2:0]  inst;
    logic [3:0]  a;
    logic [15:0] n;
    logic [15:0] es;
    logic [3:0]  ee;
    logic [2:0]  ei;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic md, logic [2:0] inst, logic [3:0] a, logic [15:0] n,
                             logic [15:0] es, logic [3:0] ee, logic [2:0] ei);
    vec_t r;
    r.md = md; r.inst = inst; r.a = a; r.n = n; r.es = es; r.ee = ee; r.ei = ei;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with an illegal instruction pending: everything must read zero
    reset = 1'b1; mode = 1'b0; inst_w = 3'b011; in_w = 4'hF; in_n = 16'h0000;
    tick();
    chk("reset out_s", out_s, 16'h0);
    chk("reset out_e", 16'(out_e), 16'h0);
    chk("reset inst_e", 16'(inst_e), 16'h0);
    chk("reset ovf", 16'(ovf), 16'h0);
    chk("reset s8 out_s", 16'(out_s_s8), 16'h0);
    tick();
    reset = 1'b0; inst_w = 3'b000; in_w = 4'h0;

    // WS capture / double buffer
    vq.push_back(v(0, 3'b001, 4'hD, 16'd0,   16'd0,  4'hD, 3'b000));
    vq.push_back(v(0, 3'b001, 4'h9, 16'd0,   16'd0,  4'h9, 3'b001));
    vq.push_back(v(0, 3'b010, 4'h5, 16'd100, 16'd85, 4'h5, 3'b010));
    vq.push_back(v(0, 3'b000, 4'h0, 16'd0,   16'd85, 4'h5, 3'b000));
    vq.push_back(v(0, 3'b001, 4'h3, 16'd0,   16'd85, 4'h3, 3'b000));
    vq.push_back(v(0, 3'b010, 4'h2, 16'd0,   16'd6,  4'h2, 3'b010));
    vq.push_back(v(0, 3'b010, 4'h3, 16'd0,   16'd9,  4'h3, 3'b010));
    vq.push_back(v(0, 3'b000, 4'h0, 16'd0,   16'd9,  4'h3, 3'b000));
    vq.push_back(v(0, 3'b001, 4'h2, 16'd0,   16'd9,  4'h2, 3'b000));
    vq.push_back(v(0, 3'b010, 4'h2, 16'd0,   16'd4,  4'h2, 3'b010));
    vq.push_back(v(0, 3'b001, 4'h6, 16'd0,   16'd4,  4'h6, 3'b000));
    vq.push_back(v(0, 3'b000, 4'h0, 16'd0,   16'd4,  4'h6, 3'b000));
    vq.push_back(v(0, 3'b010, 4'h1, 16'd0,   16'd6,  4'h1, 3'b010));
    vq.push_back(v(0, 3'b000, 4'h0, 16'd0,   16'd6,  4'h1, 3'b000));
    // load+execute: execute only, load bit still forwarded
    vq.push_back(v(0, 3'b011, 4'h5, 16'd10,  16'd40, 4'h5, 3'b011));
    vq.push_back(v(0, 3'b000, 4'h0, 16'd0,   16'd40, 4'h5, 3'b000));
    vq.push_back(v(0, 3'b010, 4'h1, 16'd0,   16'd6,  4'h1, 3'b010));
    vq.push_back(v(0, 3'b000, 4'h0, 16'd0,   16'd6,  4'h1, 3'b000));
    // OS accumulate and drain
    vq.push_back(v(1, 3'b000, 4'h0, 16'd0,   16'd6,  4'h1, 3'b000));
    for (int k = 0; k < 4; k++)
      vq.push_back(v(1, 3'b010, 4'hF, 16'h0008, 16'hFFF8, 4'hF, 3'b010));
    vq.push_back(v(1, 3'b100, 4'h0, 16'h1234, 16'hFE20, 4'hF, 3'b100));
    vq.push_back(v(1, 3'b100, 4'h0, 16'h1234, 16'h1234, 4'hF, 3'b100));
    vq.push_back(v(1, 3'b000, 4'h0, 16'h0000, 16'h1234, 4'hF, 3'b000));
    vq.push_back(v(1, 3'b100, 4'h0, 16'h0000, 16'h0000, 4'hF, 3'b100));
    vq.push_back(v(1, 3'b000, 4'h0, 16'h0000, 16'h0000, 4'hF, 3'b000));
    // mode toggle clears a loaded accumulator, keeps the WS weight
    for (int k = 0; k < 4; k++)
      vq.push_back(v(1, 3'b010, 4'hF, 16'h0008, 16'hFFF8, 4'hF, 3'b010));
    vq.push_back(v(0, 3'b000, 4'h0, 16'h0000, 16'hFFF8, 4'hF, 3'b000));
    vq.push_back(v(1, 3'b000, 4'h0, 16'h0000, 16'hFFF8, 4'hF, 3'b000));
    vq.push_back(v(1, 3'b100, 4'h0, 16'h0000, 16'h0000, 4'hF, 3'b100));
    vq.push_back(v(0, 3'b000, 4'h0, 16'h0000, 16'h0000, 4'hF, 3'b000));
    vq.push_back(v(0, 3'b010, 4'h1, 16'h0000, 16'd6,    4'h1, 3'b010));

    foreach (vq[i]) begin
      mode = vq[i].md; inst_w = vq[i].inst; in_w = vq[i].a; in_n = vq[i].n;
      tick();
      chk($sformatf("row%0d out_s", i), out_s, vq[i].es);
      chk($sformatf("row%0d out_e", i), 16'(out_e), 16'(vq[i].ee));
      chk($sformatf("row%0d inst_e", i), 16'(inst_e), 16'(vq[i].ei));
      chk($sformatf("row%0d ovf", i), 16'(ovf), 16'h0);
    end

    // 8-bit psum: positive overflow, sticky ovf, flush-edge clear
    reset = 1'b1; mode = 1'b0; inst_w = 3'b000; in_w = 4'h0; in_n = 16'h0;
    tick();
    reset = 1'b0; inst_w = 3'b001; in_w = 4'h7;
    tick();
    inst_w = 3'b010; in_w = 4'hF; in_n = 16'd120;
    tick();
    chk("sat8 pos out_s", 16'(out_s_s8), 16'h007F);
    chk("sat8 pos ovf", 16'(ovf_s8), 16'h1);
    chk("wrap8 pos out_s", 16'(out_s_w8), 16'h00E1);
    chk("wrap8 pos ovf", 16'(ovf_w8), 16'h1);
    inst_w = 3'b000; in_n = 16'h0;
    tick();
    chk("sat8 ovf sticky", 16'(ovf_s8), 16'h1);
    inst_w = 3'b100;
    tick();
    chk("sat8 ovf flush clear", 16'(ovf_s8), 16'h0);
    chk("wrap8 ovf flush clear", 16'(ovf_w8), 16'h0);
    chk("sat8 flush ws hold", 16'(out_s_s8), 16'h007F);
    // negative overflow: 15*(-8) + (-128) = -248
    inst_w = 3'b001; in_w = 4'h8;
    tick();
    inst_w = 3'b010; in_w = 4'hF; in_n = 16'h0080;
    tick();
    chk("sat8 neg out_s", 16'(out_s_s8), 16'h0080);
    chk("wrap8 neg out_s", 16'(out_s_w8), 16'h0008);
    chk("wrap8 neg ovf", 16'(ovf_w8), 16'h1);
    // reset mid-execute aborts everything
    reset = 1'b1;
    tick();
    chk("midreset out_s", 16'(out_s_s8), 16'h0);
    chk("midreset ovf", 16'(ovf_s8), 16'h0);
    chk("midreset inst_e", 16'(inst_e_s8), 16'h0);
    reset = 1'b0; inst_w = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
